// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the miniCPU sequencer: FSM states and special opcodes.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [OPCODE_W-1:0] HALT_OP = 4'hF;
    localparam logic [OPCODE_W-1:0] NOP_OP  = 4'h0;

    function automatic logic state_busy(input state_e s);
        logic b;
        case (s)
            ST_FETCH, ST_DECODE, ST_EXEC, ST_WB: b = 1'b1;
            default:                             b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_sat_counter.sv
// Saturating up-counter with async active-low reset; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] FULL = {W{1'b1}};

    // Count register: advance on inc unless already saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {W{1'b0}};
        end else if (inc && (count != FULL)) begin
            count <= count + ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute/writeback sequencer for the miniCPU.
// Optional single-step mode is enabled by defining CPU_CTRL_STEP_EN.
module cpu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int              PC_W    = 4,
    parameter logic [PC_W-1:0] PC_LAST = 4'hF,
    parameter int              CNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                step,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [PC_W-1:0]     pc,
    output logic                ir_load,
    output logic                rf_we,
    output logic                pc_inc,
    output logic [2:0]          state,
    output logic                busy,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_cnt
);

    state_e state_r;
    state_e next_s;
    logic   step_mode_s;
    logic   retire_s;

`ifdef CPU_CTRL_STEP_EN
    logic step_mode_r;
    logic step_next_s;
    assign step_mode_s = step_mode_r;
`else
    logic unused_step_s;
    assign unused_step_s = step;
    assign step_mode_s   = 1'b0;
`endif

    // Next-state decode; stop is only looked at on an instruction boundary.
    always_comb begin
        next_s = state_r;
`ifdef CPU_CTRL_STEP_EN
        step_next_s = step_mode_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    next_s = ST_FETCH;
`ifdef CPU_CTRL_STEP_EN
                    step_next_s = 1'b0;
                end else if (!start && step) begin
                    next_s      = ST_FETCH;
                    step_next_s = 1'b1;
`endif
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_FETCH:  next_s = ST_DECODE;
            ST_DECODE: begin
                if (opcode == HALT_OP) begin
                    next_s = ST_HALT;
                end else begin
                    next_s = ST_EXEC;
                end
            end
            ST_EXEC:   next_s = ST_WB;
            ST_WB: begin
                if (pc == PC_LAST) begin
                    next_s = ST_HALT;
                end else if (stop || step_mode_s) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_HALT:   next_s = ST_HALT;
            default:   next_s = ST_IDLE;
        endcase
    end

    // State and strobes are registered together so every output is a clean flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ir_load <= 1'b0;
            rf_we   <= 1'b0;
            pc_inc  <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
`ifdef CPU_CTRL_STEP_EN
            step_mode_r <= 1'b0;
`endif
        end else begin
            state_r <= next_s;
            ir_load <= (next_s == ST_FETCH);
            // opcode is already stable in EXEC, so NOP can be screened on entry to WB.
            rf_we   <= (next_s == ST_WB) && (opcode != NOP_OP);
            pc_inc  <= (next_s == ST_WB);
            busy    <= state_busy(next_s);
            halted  <= (next_s == ST_HALT);
`ifdef CPU_CTRL_STEP_EN
            step_mode_r <= step_next_s;
`endif
        end
    end

    assign state    = state_r;
    assign retire_s = (state_r == ST_WB);

    sat_counter #(
        .W(CNT_W)
    ) u_instr_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (retire_s),
        .count (instr_cnt)
    );

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed self-checking bench for cpu_seq_ctrl; a CNT_W=2 twin checks saturation.
module tb_cpu_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, stop, step;
    logic [3:0] opcode, pc;
    logic       ir_load, rf_we, pc_inc, busy, halted;
    logic [2:0] state;
    logic [7:0] instr_cnt;
    logic       ir_load2, rf_we2, pc_inc2, busy2, halted2;
    logic [2:0] state2;
    logic [1:0] instr_cnt2;
    int n_chk = 0;
    int n_fail = 0;
    int n_ir, n_pi;

    always #5 clk = ~clk;

    cpu_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
        .opcode(opcode), .pc(pc), .ir_load(ir_load), .rf_we(rf_we),
        .pc_inc(pc_inc), .state(state), .busy(busy), .halted(halted),
        .instr_cnt(instr_cnt)
    );

    cpu_seq_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
        .opcode(opcode), .pc(pc), .ir_load(ir_load2), .rf_we(rf_we2),
        .pc_inc(pc_inc2), .state(state2), .busy(busy2), .halted(halted2),
        .instr_cnt(instr_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in FETCH; returns with it sitting in WB.
    task automatic instr(input logic exp_we);
        chk("fetch_state", state, 3'd1);
        chk("fetch_ir_load", ir_load, 1'b1);
        chk("fetch_busy", busy, 1'b1);
        tick();
        chk("decode_state", state, 3'd2);
        chk("decode_ir_load", ir_load, 1'b0);
        tick();
        chk("exec_state", state, 3'd3);
        chk("exec_strobes", {ir_load, rf_we, pc_inc}, 3'b000);
        tick();
        chk("wb_state", state, 3'd4);
        chk("wb_pc_inc", pc_inc, 1'b1);
        chk("wb_rf_we", rf_we, exp_we);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
        opcode = 4'h1; pc = 4'h0;
        tick(); tick();
        chk("rst_state", state, 3'd0);
        chk("rst_outs", {ir_load, rf_we, pc_inc, busy, halted}, 5'b00000);
        chk("rst_cnt", instr_cnt, 8'd0);
        reset = 1'b1;
        tick();
        chk("idle_hold", state, 3'd0);

        // Three back-to-back instructions from pc 0..2
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instr(1'b1);
            tick();
            pc = 4'(i + 1);
        end
        chk("cnt_after3", instr_cnt, 8'd3);
        chk("cnt2_after3", instr_cnt2, 2'd3);
        chk("run_refetch", state, 3'd1);

        // stop raised in DECODE completes the instruction, then pauses
        tick();
        chk("stop_decode", state, 3'd2);
        stop = 1'b1;
        tick();
        chk("stop_no_abort", state, 3'd3);
        tick();
        chk("stop_wb", {state, rf_we, pc_inc}, {3'd4, 2'b11});
        tick();
        chk("stop_idle", {state, busy}, {3'd0, 1'b0});
        chk("cnt_after4", instr_cnt, 8'd4);
        chk("cnt2_sat4", instr_cnt2, 2'd3);

        // start while stop is still high is ignored
        start = 1'b1; tick(); start = 1'b0;
        chk("start_with_stop", state, 3'd0);
        stop = 1'b0; pc = 4'h4;

        // NOP retires without a register write
        opcode = 4'h0;
        start = 1'b1; tick(); start = 1'b0;
        instr(1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("nop_idle", state, 3'd0);
        chk("nop_cnt", instr_cnt, 8'd5);

        // pc==PC_LAST together with stop in WB halts
        opcode = 4'h1; pc = 4'hF;
        start = 1'b1; tick(); start = 1'b0;
        instr(1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("last_halt", {state, halted, busy}, {3'd5, 2'b10});
        chk("last_cnt", instr_cnt, 8'd6);
        chk("cnt2_sat6", instr_cnt2, 2'd3);
        start = 1'b1; tick(); tick(); start = 1'b0;
        chk("halt_sticky", state, 3'd5);
        chk("halt_no_strobe", {ir_load, rf_we, pc_inc}, 3'b000);

        // leave HALT, then reset asynchronously in the middle of EXEC
        reset = 1'b0; #1; reset = 1'b1;
        chk("halt_rst", {state, halted}, {3'd0, 1'b0});
        pc = 4'h0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("pre_rst_exec", state, 3'd3);
        reset = 1'b0; #1;
        chk("async_state", state, 3'd0);
        chk("async_outs", {ir_load, rf_we, pc_inc, busy, halted}, 5'b00000);
        chk("async_cnt", instr_cnt, 8'd0);
        reset = 1'b1;
        tick();

`ifdef CPU_CTRL_STEP_EN
        step = 1'b1; tick(); step = 1'b0;
        n_ir = 0; n_pi = 0;
        for (int j = 0; j < 6; j++) begin
            n_ir += int'(ir_load);
            n_pi += int'(pc_inc);
            if (j < 5) tick();
        end
        chk("step_ir_load", n_ir, 1);
        chk("step_pc_inc", n_pi, 1);
        chk("step_idle", state, 3'd0);
        chk("step_cnt", instr_cnt, 8'd1);
`else
        step = 1'b1; tick(); step = 1'b0;
        tick();
        chk("step_ignored", {state, ir_load}, {3'd0, 1'b0});
        chk("step_cnt", instr_cnt, 8'd0);
`endif

        // HALT_OP halts from DECODE without retiring
        opcode = 4'hF;
        start = 1'b1; tick(); start = 1'b0;
        chk("hop_fetch", state, 3'd1);
        tick();
        tick();
        chk("hop_halt", {state, halted}, {3'd5, 1'b1});
        chk("hop_strobes", {rf_we, pc_inc}, 2'b00);
`ifdef CPU_CTRL_STEP_EN
        chk("hop_cnt", instr_cnt, 8'd1);
`else
        chk("hop_cnt", instr_cnt, 8'd0);
`endif
        start = 1'b1; tick(); start = 1'b0;
        chk("hop_sticky", state, 3'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
